// File: rtl/upsampler_pkg.sv
// Types and constants shared by the upSampler datapath blocks and their settings maps.
package upsampler_pkg;
  localparam logic [7:0] SR_SPP      = 8'd130;
  localparam int         DEFAULT_SPP = 256;

  typedef logic [15:0] spp_t;

  typedef struct packed {
    logic [15:0] i;
    logic [15:0] q;
  } sample_t;

  function automatic spp_t clamp_spp(spp_t v, spp_t max);
    return (v > max) ? max : v;
  endfunction
endpackage

// File: rtl/upsampler_pkt_framer_if.sv
// Sample stream in from the interpolator and framed stream out to axi_wrapper_mod.
interface upsampler_pkt_framer_if;
  import upsampler_pkg::*;

  sample_t din;
  logic    din_vld;
  logic    din_rdy;
  sample_t tdata;
  logic    tlast;
  logic    tvalid;
  logic    tready;

  modport master (input din, din_vld, tready, output din_rdy, tdata, tlast, tvalid);
  modport slave  (output din, din_vld, tready, input din_rdy, tdata, tlast, tvalid);
endinterface

// File: rtl/upsampler_pkt_framer_skid.sv
// Two-entry buffer (output register + skid register) whose input ready is a flop.
module axis_skid_buf #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic [W-1:0] in_data,
  input  logic         in_vld,
  output logic         in_rdy,
  output logic [W-1:0] out_data,
  output logic         out_vld,
  input  logic         out_rdy
);
  logic [W-1:0] skid_data;
  logic         skid_vld;
  logic         in_xfer;

  assign in_xfer = in_vld & in_rdy & ~clear;

  // in_rdy always tracks "skid empty" for the next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld   <= 1'b0;
      out_data  <= '0;
      skid_vld  <= 1'b0;
      skid_data <= '0;
      in_rdy    <= 1'b0;
    end else if (clear) begin
      out_vld  <= 1'b0;
      skid_vld <= 1'b0;
      in_rdy   <= 1'b1;
    end else if (!out_vld || out_rdy) begin
      in_rdy <= 1'b1;
      if (skid_vld) begin
        out_data <= skid_data;
        out_vld  <= 1'b1;
        skid_vld <= 1'b0;
      end else begin
        out_vld <= in_xfer;
        if (in_xfer) out_data <= in_data;
      end
    end else if (in_xfer) begin
      skid_data <= in_data;
      skid_vld  <= 1'b1;
      in_rdy    <= 1'b0;
    end
  end
endmodule

// File: rtl/upsampler_pkt_framer.sv
// Frames the interpolator sample stream into SPP-long packets and counts completed packets.
module upsampler_pkt_framer
  import upsampler_pkg::spp_t;
  import upsampler_pkg::clamp_spp;
#(
  parameter logic [7:0] SR_SPP      = upsampler_pkg::SR_SPP,
  parameter int         DEFAULT_SPP = upsampler_pkg::DEFAULT_SPP,
  parameter int         MAX_SPP     = 1024
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_clear,
  input  logic                          i_set_stb,
  input  logic [7:0]                    i_set_addr,
  input  logic [31:0]                   i_set_data,
  upsampler_pkt_framer_if.master        bus,
  output spp_t                          o_spp,
  output logic [31:0]                   o_pkt_cnt
);
  localparam int CW = $clog2(MAX_SPP + 1);

  logic          spp_wr;
  logic          in_xfer;
  logic          out_xfer;
  logic          last;
  logic [CW-1:0] cnt;
  spp_t          pkt_len;
  spp_t          len;

  assign spp_wr   = i_set_stb && (i_set_addr == SR_SPP) && (i_set_data[15:0] != 16'd0);
  assign in_xfer  = bus.din_vld & bus.din_rdy & ~i_clear;
  assign out_xfer = bus.tvalid & bus.tready;

  // The first sample of a packet uses the live SPP; later samples use the latched length.
  assign len  = (cnt == '0) ? o_spp : pkt_len;
  assign last = (spp_t'(cnt) == len - 16'd1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_spp   <= spp_t'(DEFAULT_SPP);
      pkt_len <= spp_t'(DEFAULT_SPP);
      cnt     <= '0;
    end else begin
      if (spp_wr) o_spp <= clamp_spp(i_set_data[15:0], spp_t'(MAX_SPP));
      if (i_clear) begin
        cnt <= '0;
      end else if (in_xfer) begin
        if (cnt == '0) pkt_len <= o_spp;
        cnt <= last ? '0 : cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear)          o_pkt_cnt <= '0;
    else if (out_xfer && bus.tlast) o_pkt_cnt <= o_pkt_cnt + 32'd1;
  end

  axis_skid_buf #(.W(33)) u_skid (
    .clk      (i_clk),
    .rst      (i_rst),
    .clear    (i_clear),
    .in_data  ({last, bus.din}),
    .in_vld   (bus.din_vld),
    .in_rdy   (bus.din_rdy),
    .out_data ({bus.tlast, bus.tdata}),
    .out_vld  (bus.tvalid),
    .out_rdy  (bus.tready)
  );
endmodule

// File: tb/tb_upsampler_pkt_framer.sv
// Bench for upsampler_pkt_framer: scoreboarded framing plus directed SPP/clear sequences.
module tb_upsampler_pkt_framer;
  import upsampler_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        set_stb = 1'b0;
  logic [7:0]  set_addr = 8'd0;
  logic [31:0] set_data = 32'd0;
  spp_t        spp;
  logic [31:0] pkt_cnt;

  upsampler_pkt_framer_if bus();

  upsampler_pkt_framer dut (
    .i_clk(clk), .i_rst(rst), .i_clear(clear), .i_set_stb(set_stb),
    .i_set_addr(set_addr), .i_set_data(set_data), .bus(bus),
    .o_spp(spp), .o_pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Scoreboard model, evaluated at the negedge ahead of each posedge.
  logic [32:0] q[$];
  logic [15:0] m_spp;
  int          m_cnt, m_len, len_now, n_out;
  logic [31:0] m_pkt;
  logic        stall, lst;
  logic [32:0] held, exp_o;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      m_spp = 16'd256; m_cnt = 0; m_len = 0; m_pkt = 0; n_out = 0; stall = 0;
    end else begin
      chk("pkt_cnt", pkt_cnt, m_pkt);
      chk("spp", spp, m_spp);
      if (stall) chk("hold", {bus.tvalid, bus.tlast, bus.tdata}, {1'b1, held});
      if (clear) begin
        q.delete();
        m_cnt = 0; m_pkt = 0; stall = 0;
      end else begin
        if (bus.tvalid && bus.tready) begin
          n_out++;
          if (q.size() == 0) begin
            total++; bad++;
            $display("FAIL out_unexpected: got %0h want none", {bus.tlast, bus.tdata});
          end else begin
            exp_o = q.pop_front();
            chk("out_sample", {bus.tlast, bus.tdata}, exp_o);
          end
          if (bus.tlast) m_pkt = m_pkt + 32'd1;
        end
        if (bus.din_vld && bus.din_rdy) begin
          len_now = (m_cnt == 0) ? int'(m_spp) : m_len;
          if (m_cnt == 0) m_len = int'(m_spp);
          lst = (m_cnt == len_now - 1);
          q.push_back({lst, bus.din});
          m_cnt = lst ? 0 : m_cnt + 1;
        end
        stall = bus.tvalid && !bus.tready;
        held  = {bus.tlast, bus.tdata};
      end
      if (set_stb && set_addr == SR_SPP && set_data[15:0] != 16'd0)
        m_spp = (set_data[15:0] > 16'd1024) ? 16'd1024 : set_data[15:0];
    end
  end

  int sid = 0;

  task automatic reset_dut();
    rst = 1; clear = 0; set_stb = 0; bus.din_vld = 0; bus.tready = 1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_tvalid", bus.tvalid, 0);
    chk("rst_tlast", bus.tlast, 0);
    chk("rst_tdata", bus.tdata, 0);
    chk("rst_rdy", bus.din_rdy, 0);
    chk("rst_spp", spp, 256);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("rst_rdy_held", bus.din_rdy, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_rdy_after", bus.din_rdy, 1);
    @(posedge clk); #1;
  endtask

  task automatic send(input bit wr, input logic [15:0] wd, inout int waits);
    bus.din = 32'hC0DE_0000 + 32'(sid);
    bus.din_vld = 1;
    if (wr) begin set_stb = 1; set_addr = SR_SPP; set_data = {16'h0, wd}; end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.din_rdy) begin
        @(posedge clk); #1;
        bus.din_vld = 0; set_stb = 0; sid++;
        return;
      end
      waits++;
      @(posedge clk); #1 set_stb = 0;
    end
    bus.din_vld = 0;
    total++; bad++;
    $display("FAIL send_timeout: got no transfer want transfer within 200 cycles");
  endtask

  task automatic send_n(input int n, inout int waits);
    for (int i = 0; i < n; i++) send(1'b0, 16'd0, waits);
  endtask

  task automatic wr_spp(input logic [7:0] a, input logic [31:0] d);
    set_stb = 1; set_addr = a; set_data = d;
    @(posedge clk); #1 set_stb = 0;
  endtask

  task automatic drain(input int n);
    bus.tready = 1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    logic [15:0] exp_spp;
  } wr_vec_t;

  wr_vec_t tbl[9];
  int waits, sent;

  initial begin
    tbl[0] = '{8'd130, 32'd0,          16'd256};
    tbl[1] = '{8'd131, 32'd7,          16'd256};
    tbl[2] = '{8'd130, 32'd5000,       16'd1024};
    tbl[3] = '{8'd130, 32'd1,          16'd1};
    tbl[4] = '{8'd130, 32'd1025,       16'd1024};
    tbl[5] = '{8'd130, 32'h0003_FFFF,  16'd1024};
    tbl[6] = '{8'd130, 32'h0001_0003,  16'd3};
    tbl[7] = '{8'd130, 32'h0005_0000,  16'd3};
    tbl[8] = '{8'd130, 32'd5000,       16'd1024};
    bus.din = 0; bus.din_vld = 0; bus.tready = 1;

    // Default SPP at full rate: two packets, no bubbles, ready never drops.
    reset_dut();
    waits = 0;
    send_n(512, waits);
    @(posedge clk); #1;
    chk("full_rate_waits", waits, 0);
    chk("full_rate_outputs", n_out, 512);
    chk("full_rate_pkts", pkt_cnt, 2);

    // SPP=3 written at cnt=100: current packet stays 256 long.
    reset_dut();
    waits = 0;
    send_n(100, waits);
    send(1'b1, 16'd3, waits);
    @(negedge clk);
    chk("spp_mid_wr", spp, 3);
    @(posedge clk); #1;
    send_n(164, waits);
    drain(4);
    chk("spp_mid_pkts", pkt_cnt, 4);
    chk("spp_mid_empty", q.size(), 0);

    // Settings decode table: ignore zero, ignore wrong address, clamp.
    reset_dut();
    for (int i = 0; i < 9; i++) begin
      wr_spp(tbl[i].addr, tbl[i].data);
      @(negedge clk);
      chk($sformatf("spp_tbl%0d", i), spp, tbl[i].exp_spp);
      @(posedge clk); #1;
    end
    waits = 0;
    send_n(2048, waits);
    drain(4);
    chk("max_spp_pkts", pkt_cnt, 2);

    // SPP=1 with random valid/ready.
    reset_dut();
    wr_spp(8'd130, 32'd1);
    sent = 0;
    for (int cyc = 0; cyc < 20000 && sent < 1000; cyc++) begin
      bus.din = 32'hC0DE_0000 + 32'(sid);
      bus.din_vld = 1'($urandom_range(0, 1));
      bus.tready  = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (bus.din_vld && bus.din_rdy) begin sent++; sid++; end
      @(posedge clk); #1;
    end
    bus.din_vld = 0;
    chk("rand_sent", sent, 1000);
    drain(6);
    chk("rand_pkts", pkt_cnt, 1000);
    chk("rand_empty", q.size(), 0);

    // Clear with both entries occupied and a sample presented.
    reset_dut();
    wr_spp(8'd130, 32'd4);
    waits = 0;
    send_n(4, waits);
    drain(2);
    chk("clr_pre_pkts", pkt_cnt, 1);
    bus.tready = 0;
    send_n(2, waits);
    chk("clr_full_rdy", bus.din_rdy, 0);
    chk("clr_full_vld", bus.tvalid, 1);
    clear = 1; bus.din = 32'hDEAD_BEEF; bus.din_vld = 1;
    @(posedge clk); #1;
    clear = 0; bus.din_vld = 0;
    @(negedge clk);
    chk("clr_tvalid", bus.tvalid, 0);
    chk("clr_pkt_cnt", pkt_cnt, 0);
    chk("clr_rdy", bus.din_rdy, 1);
    @(posedge clk); #1;
    bus.tready = 1;
    send_n(4, waits);
    drain(4);
    chk("clr_post_pkts", pkt_cnt, 1);
    chk("clr_spp_kept", spp, 4);

    // SPP write on the first-sample transfer applies to the next packet.
    reset_dut();
    wr_spp(8'd130, 32'd4);
    waits = 0;
    send(1'b1, 16'd2, waits);
    send_n(5, waits);
    drain(4);
    chk("coinc_pkts", pkt_cnt, 2);
    chk("coinc_spp", spp, 2);
    chk("coinc_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
